anita3_event_header_buffer: RTL
===============================

ANITA3_EVENT_HEADER_BUFFER -- requirements
Module: anita3_event_header_buffer

Interface
REQ-001 SHALL have parameter NBUF, default 4, number of header slots (one per digitizer buffer A-D).
REQ-002 SHALL have parameter NWORDS, default 22, header words per slot (addresses 0x00-0x15).
REQ-003 SHALL have ports: clk33_i  in  1  sole clock; rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: event_addr_i  in  8  [7:6] slot, [5:0] word; event_dat_i  in  16  header word; event_wr_i  in  1  write strobe; event_done_i  in  1  slot header complete, slot = event_addr_i[7:6].
REQ-005 SHALL have ports: hdr_rd_addr_i  in  5  word select within head slot; hdr_dat_o  out  16  read data; hdr_ready_o  out  1  at least one complete header queued; hdr_buffer_o  out  2  head slot index; hdr_ack_i  in  1  head consumed.
REQ-006 SHALL have ports: pending_o  out  3  queued header count; overflow_o  out  1  sticky write/done to READY slot; err_clr_i  in  1  clears overflow_o.

Function
REQ-007 Each slot SHALL hold a 3-state FSM: FREE, FILLING, READY.
REQ-008 FREE->FILLING on first accepted event_wr_i to that slot; FILLING->READY on event_done_i (same cycle as a final write allowed; write is stored); READY->FREE on hdr_ack_i while it is head.
REQ-009 event_done_i to a FREE slot SHALL move it directly to READY (empty header).
REQ-010 Writes SHALL be stored at clock edge when event_wr_i=1, slot not READY, word < NWORDS; word >= NWORDS SHALL be ignored without error.
REQ-011 event_wr_i or event_done_i targeting a READY slot SHALL be discarded and SHALL set overflow_o next cycle.
REQ-012 Completed slots SHALL enter a 4-deep ready FIFO of 2-bit indices in event_done_i order; hdr_buffer_o = FIFO head.
REQ-013 hdr_ready_o SHALL equal (pending_o != 0), registered.
REQ-014 hdr_dat_o SHALL present word hdr_rd_addr_i of head slot one cycle after the address is applied; addresses >= NWORDS SHALL read 0x0000.
REQ-015 hdr_ack_i with pending_o=0 SHALL be ignored.
REQ-016 Simultaneous done and ack SHALL both take effect: pending_o unchanged, head advances, new index appended.
REQ-017 pending_o SHALL never exceed NBUF; FIFO cannot overflow because each slot is queued at most once.
REQ-018 err_clr_i SHALL clear overflow_o; a simultaneous new overflow event SHALL win (overflow_o stays 1).

Reset
REQ-019 rst_n_i low SHALL asynchronously force all slots FREE, FIFO empty, pending_o=0, hdr_ready_o=0, hdr_buffer_o=0, overflow_o=0, hdr_dat_o=0x0000.
REQ-020 Header RAM contents SHALL NOT be reset; reset mid-fill SHALL discard the partial header.
REQ-021 Deassertion SHALL be synchronised to clk33_i inside the block before use by the FSMs.

Configuration
REQ-022 Macro EVENT_HDR_WORD_VALID_EN SHALL, when defined, add per-word written flags (NBUF x NWORDS) cleared on FREE entry; reads of unwritten words return 0x0000.
REQ-023 Without EVENT_HDR_WORD_VALID_EN, reads of unwritten words SHALL return stale RAM content.

Structure
REQ-024 Shared package SHALL hold slot-state encoding (FREE=0, FILLING=1, READY=2) and header word address constants (EVID_LO=0x10, EVID_HI=0x11, STATUS=0x15, COUNT=0x01).
REQ-025 Ready FIFO SHALL be sub-module anita3_hdr_index_fifo (4x2-bit, sync, count output).
REQ-026 Header RAM SHALL be inferred as simple dual-port block RAM, 128x16 (slot*32 + word).

Verification
REQ-027 Write slot 2 words 0x00-0x15 with data=0xA500+word, done -> hdr_ready_o=1, hdr_buffer_o=2, pending_o=1, word 0x10 reads 0xA510 one cycle after address.
REQ-028 Complete slots 1,3,0 in order, ack thrice -> hdr_buffer_o sequence 1,3,0, then pending_o=0, hdr_ready_o=0.
REQ-029 Slot 1 READY, write 0x1234 to addr 0x41 -> overflow_o=1, word unchanged; err_clr_i pulse -> overflow_o=0.
REQ-030 pending_o=2, done slot 3 and ack same cycle -> pending_o=2, new head correct, slot 3 last in order.
REQ-031 Assert rst_n_i low mid-fill of slot 0 (5 words written) -> all outputs zero immediately; after release, slot 0 fill of 1 word + done reads other words as 0x0000 when EVENT_HDR_WORD_VALID_EN defined.

Source files
------------

// File: rtl/anita3_event_header_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anita3_event_header_buffer_pkg                                             |
// | Slot-state encoding, header word map and RAM geometry for the header buffer|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package anita3_event_header_buffer_pkg;

  typedef logic [1:0] slot_state_t;

  localparam slot_state_t SLOT_FREE    = 2'd0;
  localparam slot_state_t SLOT_FILLING = 2'd1;
  localparam slot_state_t SLOT_READY   = 2'd2;

  localparam logic [5:0] HDR_WORD_COUNT   = 6'h01;
  localparam logic [5:0] HDR_WORD_EVID_LO = 6'h10;
  localparam logic [5:0] HDR_WORD_EVID_HI = 6'h11;
  localparam logic [5:0] HDR_WORD_STATUS  = 6'h15;

  localparam int HDR_RAM_DEPTH = 128;
  localparam int IDX_FIFO_DEPTH = 4;

  // Each slot owns a 32-word window of the RAM; only the low NWORDS are used.
  function automatic logic [6:0] hdr_ram_addr(input logic [1:0] slot, input logic [4:0] word);
    return {slot, word};
  endfunction

endpackage
`default_nettype wire

// File: rtl/anita3_hdr_index_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anita3_hdr_index_fifo                                                      |
// | 4-deep synchronous FIFO of 2-bit slot indices with occupancy count.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module anita3_hdr_index_fifo
  import anita3_event_header_buffer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  logic [1:0] din_i,
  input  logic       pop_i,
  output logic [1:0] dout_o,
  output logic [2:0] count_o
);

  logic [IDX_FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       do_pop, do_push;

  always_comb begin
    do_pop   = pop_i && (count_q != 3'd0);
    do_push  = push_i && ((count_q != 3'd4) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/anita3_event_header_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | anita3_event_header_buffer                                                 |
// | Per-buffer event header slots, filled by the digitizer side and drained in |
// | completion order. Option: EVENT_HDR_WORD_VALID_EN (unwritten words read 0). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module anita3_event_header_buffer
  import anita3_event_header_buffer_pkg::*;
#(
  parameter int NBUF   = 4,
  parameter int NWORDS = 22
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic [7:0]  event_addr_i,
  input  logic [15:0] event_dat_i,
  input  logic        event_wr_i,
  input  logic        event_done_i,
  input  logic [4:0]  hdr_rd_addr_i,
  output logic [15:0] hdr_dat_o,
  output logic        hdr_ready_o,
  output logic [1:0]  hdr_buffer_o,
  input  logic        hdr_ack_i,
  output logic [2:0]  pending_o,
  output logic        overflow_o,
  input  logic        err_clr_i
);

  localparam logic [5:0] NWORDS_W = 6'(NWORDS);
  localparam logic [2:0] NBUF_W   = 3'(NBUF);

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        rst_n;
  slot_state_t state_q [NBUF];
  slot_state_t state_d [NBUF];
  logic        overflow_q, overflow_d;
  logic        hdr_ready_q, hdr_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] ram_rdata_q;
  logic [15:0] hdr_ram [HDR_RAM_DEPTH];
  logic [1:0]  wr_slot;
  logic [5:0]  wr_word;
  logic        slot_ok, tgt_ready, wr_accept, done_accept, ovf_event, ack_accept;
  logic        rd_in_range;
  logic [2:0]  pending_nxt;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign wr_slot = event_addr_i[7:6];
  assign wr_word = event_addr_i[5:0];

  always_comb begin
    slot_ok     = ({1'b0, wr_slot} < NBUF_W);
    tgt_ready   = slot_ok && (state_q[wr_slot] == SLOT_READY);
    wr_accept   = event_wr_i && slot_ok && !tgt_ready && (wr_word < NWORDS_W);
    done_accept = event_done_i && slot_ok && !tgt_ready;
    ovf_event   = (event_wr_i || event_done_i) && tgt_ready;
    ack_accept  = hdr_ack_i && (pending_o != 3'd0);
  end

  always_comb begin
    for (int s = 0; s < NBUF; s++) begin
      state_d[s] = state_q[s];
      case (state_q[s])
        SLOT_FREE: begin
          if (done_accept && (wr_slot == 2'(s)))    state_d[s] = SLOT_READY;
          else if (wr_accept && (wr_slot == 2'(s))) state_d[s] = SLOT_FILLING;
        end
        SLOT_FILLING: begin
          if (done_accept && (wr_slot == 2'(s)))    state_d[s] = SLOT_READY;
        end
        SLOT_READY: begin
          if (ack_accept && (hdr_buffer_o == 2'(s))) state_d[s] = SLOT_FREE;
        end
        default: state_d[s] = SLOT_FREE;
      endcase
    end
  end

  always_ff @(posedge clk33_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NBUF; s++) state_q[s] <= SLOT_FREE;
    end else begin
      for (int s = 0; s < NBUF; s++) state_q[s] <= state_d[s];
    end
  end

  anita3_hdr_index_fifo u_idx_fifo (
    .clk_i   (clk33_i),
    .rst_n_i (rst_n),
    .push_i  (done_accept),
    .din_i   (wr_slot),
    .pop_i   (ack_accept),
    .dout_o  (hdr_buffer_o),
    .count_o (pending_o)
  );

  // Ready flag tracks the post-edge count so it never lags pending_o.
  assign pending_nxt = pending_o + {2'b00, done_accept} - {2'b00, ack_accept};
  assign hdr_ready_d = (pending_nxt != 3'd0);
  assign overflow_d  = ovf_event || (overflow_q && !err_clr_i);
  assign rd_in_range = ({1'b0, hdr_rd_addr_i} < NWORDS_W);

  always_ff @(posedge clk33_i) begin
    if (wr_accept) hdr_ram[hdr_ram_addr(wr_slot, wr_word[4:0])] <= event_dat_i;
    ram_rdata_q <= hdr_ram[hdr_ram_addr(hdr_buffer_o, hdr_rd_addr_i)];
  end

`ifdef EVENT_HDR_WORD_VALID_EN
  logic [31:0] word_vld_q [NBUF];
  logic [31:0] word_vld_d [NBUF];

  always_comb begin
    for (int s = 0; s < NBUF; s++) begin
      word_vld_d[s] = word_vld_q[s];
      if ((state_d[s] == SLOT_FREE) && (state_q[s] != SLOT_FREE)) begin
        word_vld_d[s] = '0;
      end else if (wr_accept && (wr_slot == 2'(s))) begin
        word_vld_d[s][wr_word[4:0]] = 1'b1;
      end
    end
    rd_valid_d = rd_in_range && word_vld_q[hdr_buffer_o][hdr_rd_addr_i];
  end

  always_ff @(posedge clk33_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NBUF; s++) word_vld_q[s] <= '0;
    end else begin
      for (int s = 0; s < NBUF; s++) word_vld_q[s] <= word_vld_d[s];
    end
  end
`else
  assign rd_valid_d = rd_in_range;
`endif

  always_ff @(posedge clk33_i or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      hdr_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      hdr_ready_q <= hdr_ready_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign hdr_dat_o   = rd_valid_q ? ram_rdata_q : 16'h0000;
  assign hdr_ready_o = hdr_ready_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire
